// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - multiplexed common-anode seven-segment scanner
// Each digit slot is TICK_CYCLES long; brightness sets the lit portion of the slot.
module seven_segment_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_CYCLES  = 200_000,
  parameter int BRIGHT_W     = 3,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [3:0]            dig [NUM_DIGITS],
  input  logic [NUM_DIGITS-1:0] dp_en,
  input  logic [NUM_DIGITS-1:0] blank,
  input  logic [NUM_DIGITS-1:0] blink_en,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int CNT_W   = (TICK_CYCLES  > 1) ? $clog2(TICK_CYCLES)  : 1;
  localparam int IDX_W   = (NUM_DIGITS   > 1) ? $clog2(NUM_DIGITS)   : 1;
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int SLICE   = TICK_CYCLES / (2 ** BRIGHT_W);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  tick_q, tick_d;
  logic                  off_tick_q, off_tick_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BRIGHT_W-1:0]   bright_q, bright_d;
  logic [FRAME_W-1:0]    frame_q, frame_d;
  logic                  phase_q, phase_d;
  logic                  started_q, started_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [CNT_W-1:0]      on_last;
  logic                  dark;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      4'hF: hex_to_seg = 7'h0E;
    endcase
  endfunction

  // Last lit count of the slot; the anode is released the cycle after off_tick.
  assign on_last = CNT_W'((32'(bright_q) + 32'd1) * 32'(SLICE) - 32'd1);

  always_comb begin
    cnt_d      = (cnt_q == CNT_W'(TICK_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
    tick_d     = (cnt_q == CNT_W'(TICK_CYCLES - 1));
    off_tick_d = (cnt_q == on_last) && (bright_q != '1);
    idx_d      = idx_q;
    bright_d   = bright_q;
    frame_d    = frame_q;
    phase_d    = phase_q;
    started_d  = started_q;
    an_d       = an_q;
    seg_d      = seg_q;
    dp_d       = dp_q;
    dark       = 1'b0;
    if (tick_q) begin
      idx_d     = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      bright_d  = brightness;
      started_d = 1'b1;
      // The wrap on the very first tick is the reset index, not a finished scan.
      if (started_q && idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        if (frame_q == FRAME_W'(BLINK_FRAMES - 1)) begin
          frame_d = '0;
          phase_d = ~phase_q;
        end else begin
          frame_d = frame_q + 1'b1;
        end
      end
      dark = blank[idx_d] || (blink_en[idx_d] && phase_d);
      if (dark) begin
        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
      end else begin
        an_d  = ~(NUM_DIGITS'(1) << idx_d);
        seg_d = hex_to_seg(dig[idx_d]);
        dp_d  = ~dp_en[idx_d];
      end
    end else if (off_tick_q) begin
      an_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      off_tick_q <= 1'b0;
      idx_q      <= IDX_W'(NUM_DIGITS - 1);
      bright_q   <= '0;
      frame_q    <= '0;
      phase_q    <= 1'b0;
      started_q  <= 1'b0;
      an_q       <= '1;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      off_tick_q <= off_tick_d;
      idx_q      <= idx_d;
      bright_q   <= bright_d;
      frame_q    <= frame_d;
      phase_q    <= phase_d;
      started_q  <= started_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - self-checking bench for seven_segment_scanner
// Expected outputs come from a slot/scan timeline model driven by the same inputs.
module tb_seven_segment_scanner;

  localparam int N     = 3;
  localparam int T     = 16;
  localparam int BW    = 2;
  localparam int BF    = 2;
  localparam int SLICE = T / (2 ** BW);

  logic          clk = 1'b0;
  logic          reset_n;
  logic [3:0]    dig [N];
  logic [N-1:0]  dp_en, blank, blink_en;
  logic [BW-1:0] brightness;
  logic [6:0]    seg;
  logic          dp;
  logic [N-1:0]  an;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .NUM_DIGITS(N), .TICK_CYCLES(T), .BRIGHT_W(BW), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .dig(dig), .dp_en(dp_en), .blank(blank),
    .blink_en(blink_en), .brightness(brightness), .seg(seg), .dp(dp), .an(an)
  );

  int errors = 0;
  int checks = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: m = edges seen with reset_n high since the last reset edge.
  int         m = 0;
  int         cur_d = 0;
  int         cur_on = 0;
  logic       cur_dark = 1'b1;
  logic [6:0] cur_seg = 7'h7F;
  logic       cur_dp = 1'b1;
  logic [N-1:0] exp_an;
  logic [6:0]   exp_seg;
  logic         exp_dp;

  task automatic check_outputs(input string tag);
    checks++;
    assert (an === exp_an) else begin
      errors++;
      $error("FAIL %s an m=%0d got=%b exp=%b", tag, m, an, exp_an);
    end
    checks++;
    assert (seg === exp_seg) else begin
      errors++;
      $error("FAIL %s seg m=%0d got=%h exp=%h", tag, m, seg, exp_seg);
    end
    checks++;
    assert (dp === exp_dp) else begin
      errors++;
      $error("FAIL %s dp m=%0d got=%b exp=%b", tag, m, dp, exp_dp);
    end
  endtask

  task automatic step(input string tag);
    int s, scan;
    if (!reset_n) begin
      m = 0;
    end else begin
      m++;
      if (m > T && (m - 1) % T == 0) begin
        s        = (m - 1) / T - 1;
        cur_d    = s % N;
        scan     = s / N;
        cur_dark = blank[cur_d] || (blink_en[cur_d] && ((scan / BF) % 2 == 1));
        cur_seg  = seg_tab[dig[cur_d]];
        cur_dp   = ~dp_en[cur_d];
        cur_on   = (int'(brightness) + 1) * SLICE;
      end
    end
    if (m <= T || cur_dark) begin
      exp_an  = '1;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
    end else begin
      exp_seg = cur_seg;
      exp_dp  = cur_dp;
      exp_an  = (((m - 1) % T) < cur_on) ? ~(N'(1) << cur_d) : '1;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) step(tag);
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    run(n, "reset");
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    dig[0]     = 4'h0;
    dig[1]     = 4'h1;
    dig[2]     = 4'h2;
    dp_en      = '0;
    blank      = '0;
    blink_en   = '0;
    brightness = 2'd3;
    do_reset(3);

    // Scan order with full brightness
    run(T * 6 + 1, "scan");

    // PWM duty at each brightness, with mid-slot changes
    brightness = 2'd0;
    run(T * 3, "pwm0");
    brightness = 2'd1;
    run(T * 3, "pwm1");
    for (int i = 0; i < 6; i++) begin
      run($urandom_range(T - 1, 1), "pwm_mid");
      brightness = BW'($urandom_range(3));
    end
    brightness = 2'd3;

    // Decimal point and blank
    dp_en = 3'b010;
    blank = 3'b100;
    run(T * 6, "dp_blank");
    dp_en = '0;
    blank = '0;

    // Blink from a fresh reset: digit 0 dark during scans 2-3
    blink_en = 3'b001;
    do_reset(1);
    run(T * (N * 6 + 1) + 1, "blink");

    // Every hex encoding on every digit position
    for (int v = 0; v < 16; v++) begin
      for (int i = 0; i < N; i++) dig[i] = 4'((v + i) % 16);
      run(T, "hex");
    end

    // Randomized operation
    for (int i = 0; i < T * 40; i++) begin
      if ($urandom_range(7) == 0) begin
        for (int k = 0; k < N; k++) dig[k] = 4'($urandom_range(15));
        dp_en      = N'($urandom);
        blank      = N'($urandom) & N'($urandom);
        blink_en   = N'($urandom);
        brightness = BW'($urandom);
      end
      step("random");
    end

    // Mid-operation reset during the digit-1 slot
    blank      = '0;
    blink_en   = '0;
    brightness = 2'd3;
    dig[0]     = 4'h7;
    begin
      int guard;
      guard = 0;
      while (!(m > T && cur_d == 1 && (m - 1) % T == 5) && guard < 300) begin
        step("seek");
        guard++;
      end
      checks++;
      assert (guard < 300) else begin
        errors++;
        $error("FAIL seek_digit1 got=timeout exp=digit1_slot");
      end
    end
    reset_n = 1'b0;
    step("midreset");
    reset_n = 1'b1;
    run(T, "post_reset_dark");
    step("post_reset_first");
    checks++;
    assert (an === 3'b110 && seg === 7'h78) else begin
      errors++;
      $error("FAIL first_slot_after_reset got=%b/%h exp=110/78", an, seg);
    end
    run(T * 4, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
Parametrised multiplexed seven-segment scanner for N common-anode digits.
Adds per-digit decimal point, blank mask and blink mask, plus a runtime brightness setting via on-time PWM within each digit slot.
Sits in the FPGA board wrapper between CPU debug/status registers and the board display pins.
Targets the Basys3 4-digit display by default and scales to wider displays.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=2, need not be a power of 2)
TICK_CYCLES, 200_000, clock cycles per digit slot (must be >= 2**BRIGHT_W)
BRIGHT_W, 3, brightness control width; 2**BRIGHT_W duty steps
BLINK_FRAMES, 64, full scans (NUM_DIGITS slots each) per blink half-period

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
dig  input  4 x NUM_DIGITS (unpacked array)  hex value per digit; index 0 = rightmost
dp_en  input  NUM_DIGITS  1 = light decimal point of digit i
blank  input  NUM_DIGITS  1 = digit i fully dark
blink_en  input  NUM_DIGITS  1 = digit i dark during blink-off phase
brightness  input  BRIGHT_W  duty select; 0 = dimmest, all-ones = 100%
seg  output  7  active-low segments {g,f,e,d,c,b,a}
dp  output  1  active-low decimal point
an  output  NUM_DIGITS  active-low anodes; at most one bit low

Behaviour:
- Reset is synchronous and active-low on clk. While reset_n=0:
  - cnt=0, tick=0, off_tick=0, digit_idx=NUM_DIGITS-1, blink_phase=0, frame_cnt=0.
  - an=all 1s, seg=7'h7F, dp=1.
- Reset asserted mid-scan takes effect on the next edge; all state returns to the reset values.
- Slot counter: cnt runs 0..TICK_CYCLES-1 and wraps to 0. Registered tick=1 for exactly one cycle when cnt==TICK_CYCLES-1. The first tick is high TICK_CYCLES cycles after reset release.
- Digit advance: on the edge where tick=1:
  - digit_idx <= (digit_idx==NUM_DIGITS-1) ? 0 : digit_idx+1. The first slot after reset shows digit 0.
  - an, seg and dp register values for the new index in the same edge (no partial update).
  - brightness is sampled into bright_q on the same edge. Changes mid-slot have no effect until the next slot.
- Segment encoding: 0..F active-low: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- dp = ~dp_en[idx].
- Dark digit: when blank[idx], or (blink_en[idx] and blink_phase=1):
  - an=all 1s, seg=7'h7F, dp=1 for the whole slot.
  - Scan timing is unchanged.
- PWM: SLICE = TICK_CYCLES / 2**BRIGHT_W (integer divide). on_limit = (bright_q+1)*SLICE.
  - Registered off_tick=1 for one cycle when cnt==on_limit-1 and bright_q != all-ones. On that edge an <= all 1s; seg and dp hold.
  - bright_q = all-ones: digit stays lit the full slot.
  - If tick and off_tick coincide, tick wins.
- Blink: frame_cnt increments on each wrap of digit_idx NUM_DIGITS-1 -> 0. At frame_cnt==BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- Inputs dig, dp_en, blank and blink_en are sampled only on tick edges.
- Counter widths: $clog2(TICK_CYCLES), $clog2(NUM_DIGITS), $clog2(BLINK_FRAMES), each minimum 1.

Test Plan:
1. Scan order (NUM_DIGITS=3, TICK_CYCLES=16, BRIGHT_W=2, brightness=3, dig={2,1,0}): release reset -> an=111 for 16 cycles, then 110/seg=40, 101/seg=79, 011/seg=24, then 110 again. Each slot lasts 16 cycles; the index wraps 2->0.
2. PWM: same config, brightness=0 -> an low for 4 cycles of each 16-cycle slot. brightness=1 -> 8 cycles. brightness=3 -> an low 16/16. Changing brightness mid-slot alters only the next slot.
3. Decimal point and blank: dp_en=3'b010, blank=3'b100 -> dp=0 only in the digit-1 slot. In the digit-2 slot an=111, seg=7F, dp=1. Slot length is still 16.
4. Blink (BLINK_FRAMES=2): blink_en=3'b001 -> digit 0 lit for scans 0-1, dark for scans 2-3, lit for 4-5. Digits 1 and 2 are always lit.
5. Mid-operation reset: assert reset_n=0 for 1 cycle during the digit-1 slot -> next edge gives an=111, seg=7F, dp=1. After release, the first tick lands 16 cycles later and shows digit 0. Blink phase restarts at 0.
6. Default parameters (NUM_DIGITS=4, TICK_CYCLES=200_000, BRIGHT_W=3): brightness=0 -> on-time exactly 25_000 cycles per slot. Full scan = 800_000 cycles. All 16 hex encodings checked via dig sweep.
